// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential instruction reads against a
// one-cycle-latency memory, buffers the returned words with their PCs in a
// small in-order FIFO, and presents the oldest entry to decode. A redirect
// (flush) empties the queue, drops the in-flight response and restarts the
// fetch stream at flush_target.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        flush,
  input  logic [15:0] flush_target,
  input  logic        halt,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [15:0] d_inst,
  output logic [15:0] d_pc,
  output logic [3:0]  occupancy
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_W   = 5'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [15:0]   pc_q, pc_d;
  logic [15:0]   req_pc_q, req_pc_d;     // PC of the request whose data arrives this cycle
  logic          inflight_q, inflight_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;

  logic [15:0]   inst_mem [DEPTH];
  logic [15:0]   pc_mem   [DEPTH];

  logic          push;
  logic          pop;
  logic [4:0]    credits_used;

  // Output decode and credit check. Reset and flush gate the handshake
  // signals directly so they take effect in the same cycle they are seen.
  assign mem_addr     = pc_q;
  assign occupancy    = reset ? 4'd0 : count_q;
  assign d_valid      = ~reset & ~flush & (count_q != 4'd0);
  assign d_inst       = inst_mem[head_q];
  assign d_pc         = pc_mem[head_q];
  assign pop          = d_valid & d_ready;
  assign push         = inflight_q & ~flush & ~reset;
  // A slot is reserved for the in-flight response; a pop this cycle frees one.
  assign credits_used = {1'b0, count_q} + {4'd0, inflight_q};
  assign mem_req      = ~reset & ~flush & ~halt &
                        (credits_used < (DEPTH_W + {4'd0, pop}));

  // Next-state logic: flush overrides push, pop and PC advance.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      pc_d       = flush_target;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = 4'd0;
    end else begin
      inflight_d = mem_req;
      if (mem_req) begin
        pc_d     = pc_q + 16'd1;
        req_pc_d = pc_q;
      end
      if (push) tail_d = tail_q + PTR_ONE;
      if (pop)  head_d = head_q + PTR_ONE;
      count_d = count_q + {3'd0, push} - {3'd0, pop};
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= 16'd0;
      req_pc_q   <= 16'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 4'd0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage: capture the returning word and its PC at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= mem_data;
      pc_mem[tail_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = 16'h0000;
  logic        flush;
  logic [15:0] flush_target;
  logic        halt;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_inst;
  logic [15:0] d_pc;
  logic [3:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .flush(flush), .flush_target(flush_target),
    .halt(halt), .d_ready(d_ready), .d_valid(d_valid), .d_inst(d_inst),
    .d_pc(d_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, word = address + 0x1000.
  always @(posedge clk) mem_data <= mem_req ? (mem_addr + 16'h1000) : 16'hDEAD;

  // Reference model: list of PCs requested and not yet consumed or flushed
  // (includes the one still in flight), plus the next fetch PC.
  logic [15:0] mq[$];
  logic [15:0] m_pc = 16'h0000;
  bit          m_inflight = 1'b0;
  int          exp_occ;
  bit          exp_valid;
  bit          exp_req;

  function automatic void exp_calc();
    bit pop_e;
    if (reset) begin
      exp_occ = 0; exp_valid = 0; exp_req = 0;
    end else begin
      exp_occ   = mq.size() - int'(m_inflight);
      exp_valid = (exp_occ != 0) && !flush;
      pop_e     = exp_valid && d_ready;
      exp_req   = !flush && !halt && ((mq.size() - int'(pop_e)) < DEPTH);
    end
  endfunction

  task automatic tick();
    exp_calc();
    if (reset) begin
      mq.delete(); m_inflight = 0; m_pc = 16'h0000;
    end else if (flush) begin
      mq.delete(); m_inflight = 0; m_pc = flush_target;
    end else begin
      if (exp_valid && d_ready) void'(mq.pop_front());
      if (exp_req) begin mq.push_back(m_pc); m_pc = m_pc + 16'd1; end
      m_inflight = exp_req;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    exp_calc();
  endtask

  task automatic do_reset();
    reset = 1; flush = 0; halt = 0; d_ready = 0; flush_target = 16'h0;
    settle(); tick();
    settle(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; flush = 1; halt = 0; d_ready = 1; flush_target = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_vec++;
      if ({mem_req, d_valid, occupancy} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got req=%b valid=%b occ=%0d, need 0/0/0", mem_req, d_valid, occupancy);
      end
      tick();
    end
    flush = 0;
  endtask

  task automatic test_stream();
    do_reset();
    d_ready = 1;
    settle();
    n_vec++;
    if ({mem_req, mem_addr, d_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL stream_first_req: got req=%b addr=%h valid=%b, need 1/0000/0", mem_req, mem_addr, d_valid);
    end
    tick();
    settle();
    n_vec++;
    if ({d_valid, mem_addr} !== {1'b0, 16'h0001}) begin
      n_err++;
      $display("FAIL stream_second: got valid=%b addr=%h, need 0/0001", d_valid, mem_addr);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      settle();
      n_vec++;
      if ({d_valid, d_pc, d_inst} !== {1'b1, 16'(k), 16'(k) + 16'h1000}) begin
        n_err++;
        $display("FAIL stream_k%0d: got valid=%b pc=%h inst=%h, need 1/%h/%h", k, d_valid, d_pc, d_inst, 16'(k), 16'(k) + 16'h1000);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    d_ready = 0;
    for (int i = 0; i < 10; i++) begin settle(); tick(); end
    settle();
    n_vec++;
    if ({occupancy, mem_req, d_valid, d_pc} !== {4'(DEPTH), 1'b0, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL bp_full: got occ=%0d req=%b valid=%b pc=%h, need %0d/0/1/0000", occupancy, mem_req, d_valid, d_pc, DEPTH);
    end
    d_ready = 1;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_vec++;
      if ({d_valid, d_pc} !== {1'b1, 16'(k)}) begin
        n_err++;
        $display("FAIL bp_drain_k%0d: got valid=%b pc=%h, need 1/%h", k, d_valid, d_pc, 16'(k));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    bit found = 0;
    do_reset();
    d_ready = 0;
    for (int i = 0; i < 4; i++) begin settle(); tick(); end
    settle();
    n_vec++;
    if ({occupancy, mem_req} !== {4'd3, 1'b0}) begin
      n_err++;
      $display("FAIL flush_setup: got occ=%0d req=%b, need 3/0", occupancy, mem_req);
    end
    flush = 1; flush_target = 16'h0040;
    settle();
    n_vec++;
    if ({d_valid, mem_req} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_cycle: got valid=%b req=%b, need 0/0", d_valid, mem_req);
    end
    tick();
    flush = 0; d_ready = 1;
    settle();
    n_vec++;
    if ({occupancy, mem_req, mem_addr} !== {4'd0, 1'b1, 16'h0040}) begin
      n_err++;
      $display("FAIL flush_after: got occ=%0d req=%b addr=%h, need 0/1/0040", occupancy, mem_req, mem_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); settle();
      found = d_valid;
    end
    n_vec++;
    if ({found, d_pc, d_inst} !== {1'b1, 16'h0040, 16'h1040}) begin
      n_err++;
      $display("FAIL flush_first_pc: got found=%b pc=%h inst=%h, need 1/0040/1040", found, d_pc, d_inst);
    end
    tick(); settle();
    n_vec++;
    if ({d_valid, d_pc} !== {1'b1, 16'h0041}) begin
      n_err++;
      $display("FAIL flush_second_pc: got valid=%b pc=%h, need 1/0041", d_valid, d_pc);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] seq [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bit found = 0;
    d_ready = 1; flush = 1; flush_target = 16'hFFFE;
    settle(); tick();
    flush = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      found = d_valid;
      if (!found) tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({d_valid, d_pc} !== {1'b1, seq[k]}) begin
        n_err++;
        $display("FAIL wrap_k%0d: got valid=%b pc=%h, need 1/%h", k, d_valid, d_pc, seq[k]);
      end
      tick(); settle();
    end
  endtask

  task automatic test_halt();
    int got = 0;
    do_reset();
    d_ready = 0;
    for (int i = 0; i < 3; i++) begin settle(); tick(); end
    settle();
    n_vec++;
    if (occupancy !== 4'd2) begin
      n_err++;
      $display("FAIL halt_setup: got occ=%0d, need 2", occupancy);
    end
    halt = 1; d_ready = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_vec++;
      if (mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL halt_req_c%0d: got req=%b, need 0", i, mem_req);
      end
      if (d_valid) begin
        n_vec++;
        if (d_pc !== 16'(got)) begin
          n_err++;
          $display("FAIL halt_pc_%0d: got pc=%h, need %h", got, d_pc, 16'(got));
        end
        got++;
      end
      tick();
    end
    settle();
    n_vec++;
    if ({got, d_valid} !== {32'd3, 1'b0}) begin
      n_err++;
      $display("FAIL halt_delivered: got count=%0d valid=%b, need 3/0", got, d_valid);
    end
    halt = 0;
    settle();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0003}) begin
      n_err++;
      $display("FAIL halt_resume: got req=%b addr=%h, need 1/0003", mem_req, mem_addr);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 99) < 5);
      flush_target = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      halt         = ($urandom_range(0, 99) < 15);
      d_ready      = ($urandom_range(0, 99) < 70);
      settle();
      n_vec++;
      if (occupancy !== 4'(exp_occ) || occupancy > 4'(DEPTH)) begin
        n_err++;
        $display("FAIL rnd_occ c%0d: got %0d, need %0d", c, occupancy, exp_occ);
      end
      n_vec++;
      if ({d_valid, mem_req} !== {exp_valid, exp_req}) begin
        n_err++;
        $display("FAIL rnd_ctrl c%0d: got valid=%b req=%b, need %b/%b", c, d_valid, mem_req, exp_valid, exp_req);
      end
      if (exp_req) begin
        n_vec++;
        if (mem_addr !== m_pc) begin
          n_err++;
          $display("FAIL rnd_addr c%0d: got %h, need %h", c, mem_addr, m_pc);
        end
      end
      if (exp_valid) begin
        n_vec++;
        if ({d_pc, d_inst} !== {mq[0], mq[0] + 16'h1000}) begin
          n_err++;
          $display("FAIL rnd_head c%0d: got pc=%h inst=%h, need %h/%h", c, d_pc, d_inst, mq[0], mq[0] + 16'h1000);
        end
      end
      tick();
    end
    reset = 0; flush = 0; halt = 0;
  endtask

  initial begin
    reset = 1; flush = 0; halt = 0; d_ready = 0; flush_target = 16'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
